// File: rtl/d_ff_up_counter_if.sv
// Control/status bundle for d_ff_up_counter.
// The master drives the controls and din; the slave returns the count and flags.
interface d_ff_up_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic             ovf;

  modport master (
    output en, clr, load, din,
    input  q, tc, wrap, ovf
  );

  modport slave (
    input  en, clr, load, din,
    output q, tc, wrap, ovf
  );
endinterface

// File: rtl/d_ff_up_counter.sv
// Modulo-(MOD_MAX+1) up counter: sync clear/load/enable, wrap pulse, sticky overflow.
// Define UP_COUNTER_SATURATE_EN to hold at MOD_MAX instead of wrapping.
module d_ff_up_counter #(
  parameter int WIDTH   = 4,
  parameter int MOD_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  d_ff_up_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD_MAX);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] din_c;
  logic             wrap_r;
  logic             wrap_nxt;
  logic             ovf_r;
  logic             ovf_nxt;
  logic             at_max;
  logic             sel_clr;
  logic             sel_load;
  logic             sel_inc;

  assign at_max = (q_r == MAXV);
  assign din_c  = (bus.din > MAXV) ? MAXV : bus.din;

  // One-hot select so the decoder below has disjoint items.
  assign sel_clr  = bus.clr;
  assign sel_load = bus.load & ~bus.clr;
  assign sel_inc  = bus.en & ~bus.load & ~bus.clr;

  always_comb begin
    q_nxt    = q_r;
    wrap_nxt = 1'b0;
    ovf_nxt  = ovf_r;
    unique case (1'b1)
      sel_clr: begin
        q_nxt   = '0;
        ovf_nxt = 1'b0;
      end
      sel_load: begin
        q_nxt = din_c;
      end
      sel_inc: begin
        if (at_max) begin
`ifdef UP_COUNTER_SATURATE_EN
          q_nxt    = MAXV;
          ovf_nxt  = 1'b1;
`else
          q_nxt    = '0;
          wrap_nxt = 1'b1;
          ovf_nxt  = 1'b1;
`endif
        end else begin
          q_nxt = q_r + WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r    <= '0;
      wrap_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      q_r    <= q_nxt;
      wrap_r <= wrap_nxt;
      ovf_r  <= ovf_nxt;
    end
  end

  assign bus.q    = q_r;
  assign bus.wrap = wrap_r;
  assign bus.ovf  = ovf_r;
  // Unregistered so a following stage can use it directly as its enable.
  assign bus.tc   = sel_inc & at_max;

endmodule

// File: doc/d_ff_up_counter.md
D_FF_UP_COUNTER -- requirements
Module: d_ff_up_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, legal range 2..16.
REQ-002 Parameter MOD_MAX, default 15: terminal count value, legal range 1..2^WIDTH-1.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port en, input, 1: count enable.
REQ-006 Port clr, input, 1: synchronous clear to zero.
REQ-007 Port load, input, 1: synchronous parallel load strobe.
REQ-008 Port din, input, WIDTH: load value.
REQ-009 Port q, output, WIDTH: registered count value.
REQ-010 Port tc, output, 1: combinational terminal-count indicator.
REQ-011 Port wrap, output, 1: registered one-cycle wrap pulse.
REQ-012 Port ovf, output, 1: registered sticky overflow flag.

Function
REQ-013 Priority per rising edge SHALL be clr > load > en > hold.
REQ-014 clr=1: q SHALL become 0, wrap SHALL become 0 and ovf SHALL become 0 at the next edge.
REQ-015 load=1 with clr=0: q SHALL become din at the next edge; a din value above MOD_MAX SHALL be clamped to MOD_MAX.
REQ-016 load=1 SHALL NOT alter ovf, and SHALL force wrap to 0 at that edge.
REQ-017 en=1 with clr=0, load=0, q<MOD_MAX: q SHALL become q+1 at the next edge; latency is one cycle.
REQ-018 en=1 with clr=0, load=0, q==MOD_MAX: q SHALL become 0 at the next edge, wrap SHALL be 1 for exactly that following cycle, and ovf SHALL become 1.
REQ-019 en=0 with clr=0, load=0: q and ovf SHALL hold, and wrap SHALL be 0.
REQ-020 tc SHALL equal en & (q==MOD_MAX) & ~clr & ~load, with no register delay, for cascading into the en input of the next stage.
REQ-021 Arithmetic SHALL be unsigned at WIDTH bits; q SHALL never exceed MOD_MAX after any edge.
REQ-022 ovf SHALL remain 1 until rst or clr; further wraps while ovf=1 SHALL keep it at 1.
REQ-023 Back-to-back wraps are possible only when MOD_MAX=1 with en held high; in that case wrap SHALL pulse every second cycle.

Reset
REQ-024 rst=1 SHALL immediately, without waiting for clk, force q=0, wrap=0 and ovf=0.
REQ-025 While rst=1, all of clr, load, en and din SHALL be ignored.
REQ-026 Reset asserted mid-count SHALL discard the count; the first enabled edge after deassertion SHALL yield q=1.
REQ-027 rst deassertion SHALL be treated as synchronous to clk by the integrator; the block SHALL contain no reset synchronizer.

Configuration
REQ-028 Macro UP_COUNTER_SATURATE_EN, defined: at q==MOD_MAX with en=1, q SHALL hold at MOD_MAX instead of wrapping; wrap SHALL stay 0 permanently; ovf SHALL set on the first attempted increment at MOD_MAX; tc SHALL follow REQ-020 unchanged.
REQ-029 Macro UP_COUNTER_SATURATE_EN, undefined: wrap-around behaviour per REQ-018 applies.

Verification
REQ-030 Bench: rst pulse between clk edges mid-count (q=9) -> q=0, wrap=0 and ovf=0 immediately, before the next clk edge.
REQ-031 Bench: WIDTH=4, MOD_MAX=15, en held 17 cycles from 0 -> q sequence 1..15,0,1; wrap high only in the cycle q=0; ovf=1 from that cycle onward; tc high only while q=15.
REQ-032 Bench: MOD_MAX=9, load=1 with din=12 -> q=9 and tc=1 (given en=1); the next enabled edge -> q=0, wrap=1.
REQ-033 Bench: clr=1, load=1, en=1 together at q=7 with ovf=1 -> q=0, ovf=0, wrap=0.
REQ-034 Bench: two instances with tc of stage 0 driving en of stage 1, 256 enabled cycles -> combined count reads 0x00 with stage-1 ovf=1 (WIDTH=4, MOD_MAX=15 both).
REQ-035 Bench: UP_COUNTER_SATURATE_EN defined, MOD_MAX=5, en held 8 cycles from 0 -> q sequence 1,2,3,4,5,5,5,5; wrap never asserted; ovf=1 from the sixth edge.
